// File: rtl/dmem_responder_if.sv
// Request/response bus between a load/store unit and the dmem_responder
// data memory: one request channel, one registered response channel.
interface dmem_responder_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [31:0] req_addr_i;
  logic [31:0] req_data_i;
  logic        req_write_i;
  logic [1:0]  req_width_i;
  logic        req_unsigned_i;
  logic        resp_valid_ro;
  logic        resp_ready_i;
  logic [31:0] resp_data_ro;
  logic        resp_err_ro;

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, req_write_i, req_width_i,
           req_unsigned_i, resp_ready_i,
    output req_ready_o, resp_valid_ro, resp_data_ro, resp_err_ro
  );

  modport master (
    output req_valid_i, req_addr_i, req_data_i, req_write_i, req_width_i,
           req_unsigned_i, resp_ready_i,
    input  req_ready_o, resp_valid_ro, resp_data_ro, resp_err_ro
  );
endinterface

// File: rtl/dmem_responder.sv
// Single-ported word-organised data memory answering byte/half/word loads and
// stores with one outstanding request, misalignment and range checking.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  dmem_responder_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t      state;
  logic        ready_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_data_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]      offset;
  logic [29:0]      word_off;
  logic [IDX_W-1:0] idx;
  logic             out_of_range;
  logic             misaligned;
  logic             bad_width;
  logic             req_err;
  logic             accept;
  logic [3:0]       be;
  logic [31:0]      wdata;

  logic [31:0] rd_word_p0;
  logic [1:0]  lane_p0;
  logic [1:0]  width_p0;
  logic        uns_p0;

  // Select the addressed lane, shift it to bit 0 and extend.
  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  lane,
                                              input logic [1:0]  width,
                                              input logic        uns);
    logic [31:0]        sh;
    logic signed [31:0] sx;
    sh = word >> {lane, 3'b000};
    case (width)
      2'b00: begin
        sx = $signed(sh[7:0]);
        return uns ? {24'h0, sh[7:0]} : sx;
      end
      2'b01: begin
        sx = $signed(sh[15:0]);
        return uns ? {16'h0, sh[15:0]} : sx;
      end
      default: return word;
    endcase
  endfunction

  // Offset bits [1:0] equal the address lane because BASE_ADDR is aligned.
  assign offset       = bus.req_addr_i - BASE_ADDR;
  assign word_off     = offset[31:2];
  assign idx          = word_off[IDX_W-1:0];
  assign out_of_range = (bus.req_addr_i < BASE_ADDR) ||
                        ({2'b00, word_off} >= 32'(DEPTH_WORDS));
  assign bad_width    = (bus.req_width_i == 2'b11);
  assign misaligned   = ((bus.req_width_i == 2'b01) && offset[0]) ||
                        ((bus.req_width_i == 2'b10) && (offset[1:0] != 2'b00));
  assign req_err      = out_of_range || bad_width || misaligned;
  assign accept       = bus.req_valid_i && ready_q && !rst;

  always_comb begin
    be    = 4'b1111;
    wdata = bus.req_data_i;
    case (bus.req_width_i)
      2'b00: begin
        be    = 4'b0001 << offset[1:0];
        wdata = {4{bus.req_data_i[7:0]}};
      end
      2'b01: begin
        be    = offset[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.req_data_i[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = bus.req_data_i;
      end
    endcase
  end

  // Stage p0: array write or read at the acceptance edge; array is never reset.
  always_ff @(posedge clk) begin
    if (accept && !req_err) begin
      if (bus.req_write_i) begin
        for (int b = 0; b < 4; b++) begin
          if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rd_word_p0 <= mem[idx];
        lane_p0    <= offset[1:0];
        width_p0   <= bus.req_width_i;
        uns_p0     <= bus.req_unsigned_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (req_err || bus.req_write_i) begin
              state        <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= req_err;
              resp_data_q  <= 32'h0;
            end else begin
              state <= READ;
            end
          end
        end
        // Stage p1: extended load result becomes the registered response.
        READ: begin
          state        <= RESP;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b0;
          resp_data_q  <= load_extend(rd_word_p0, lane_p0, width_p0, uns_p0);
        end
        RESP: begin
          if (bus.resp_ready_i) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            ready_q      <= 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
        end
      endcase
    end
  end

  assign bus.req_ready_o   = ready_q;
  assign bus.resp_valid_ro = resp_valid_q;
  assign bus.resp_err_ro   = resp_err_q;
  assign bus.resp_data_ro  = resp_data_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Table-driven scoreboard bench for dmem_responder: load/store vectors plus
// hand-written stall and mid-transaction reset sequences.
module tb_dmem_responder;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  dmem_responder_if dif();

  dmem_responder dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  wd;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];

  function automatic vec_t mk(input logic wr, input logic [1:0] wd, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp, input logic err);
    vec_t v;
    v.wr = wr; v.wd = wd; v.uns = uns; v.addr = addr;
    v.data = data; v.exp = exp; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    dif.req_write_i    = v.wr;
    dif.req_width_i    = v.wd;
    dif.req_unsigned_i = v.uns;
    dif.req_addr_i     = v.addr;
    dif.req_data_i     = v.data;
    dif.req_valid_i    = 1'b1;
  endtask

  // Issue one request, check latency, then pop the scoreboard on the response.
  task automatic run_vec(input vec_t v, input string name);
    int   lat;
    exp_t e;
    lat = 0;
    while (!dif.req_ready_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    drive(v);
    exp_q.push_back({v.exp, v.err});
    @(posedge clk); #1;
    dif.req_valid_i = 1'b0;
    chk({name, "_busy"}, {31'h0, dif.req_ready_o}, 32'h0);
    lat = 1;
    while (!dif.resp_valid_ro && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_lat"}, lat, (v.wr || v.err) ? 32'd1 : 32'd2);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (dif.resp_valid_ro) begin
        chk({name, "_data"}, dif.resp_data_ro, e.data);
        chk({name, "_err"}, {31'h0, dif.resp_err_ro}, {31'h0, e.err});
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          seen;
    logic [31:0] held;
    vec_t        v;

    checks = 0;
    errors = 0;
    rst = 1'b1;
    dif.req_valid_i = 1'b0; dif.req_write_i = 1'b0; dif.req_width_i = 2'b10;
    dif.req_unsigned_i = 1'b0; dif.req_addr_i = 32'h0; dif.req_data_i = 32'h0;
    dif.resp_ready_i = 1'b1;

    //   wr  wd     uns  addr           data           expected       err
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0,          0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF,  0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0012, 32'h0000_005A, 32'h0,          0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF,  0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0013, 32'h0,         32'hFFFF_FFDE,  0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0013, 32'h0,         32'h0000_00DE,  0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0012, 32'h0,         32'hFFFF_DE5A,  0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0011, 32'h0000_1234, 32'h0,          1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_000E, 32'h0,         32'h0,          1));
    vecs.push_back(mk(0, 2'b11, 0, 32'h0000_0010, 32'h0,         32'h0,          1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_1000, 32'h0,         32'h0,          1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0,         32'hDE5A_BEEF,  0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0000, 32'h1122_3344, 32'h0,          0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0020, 32'h0000_0000, 32'h0,          0));
    vecs.push_back(mk(1, 2'b01, 0, 32'h0000_0022, 32'hABCD_8000, 32'h0,          0));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_0020, 32'hFFFF_FF7F, 32'h0,          0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0022, 32'h0,         32'h0000_8000,  0));
    vecs.push_back(mk(0, 2'b01, 0, 32'h0000_0022, 32'h0,         32'hFFFF_8000,  0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0020, 32'h0,         32'h0000_007F,  0));
    vecs.push_back(mk(0, 2'b00, 0, 32'h0000_0021, 32'h0,         32'h0000_0000,  0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0021, 32'hFFFF_FFFF, 32'h0,          1));
    vecs.push_back(mk(1, 2'b00, 0, 32'h0000_1000, 32'h0000_00EE, 32'h0,          1));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0020, 32'h0,         32'h8000_007F,  0));
    vecs.push_back(mk(0, 2'b10, 0, 32'h0000_0000, 32'h0,         32'h1122_3344,  0));
    vecs.push_back(mk(1, 2'b10, 0, 32'h0000_0FFC, 32'h1234_5678, 32'h0,          0));
    vecs.push_back(mk(0, 2'b00, 1, 32'h0000_0FFF, 32'h0,         32'h0000_0012,  0));
    vecs.push_back(mk(0, 2'b01, 1, 32'h0000_0FFE, 32'h0,         32'h0000_1234,  0));
    vecs.push_back(mk(0, 2'b10, 0, 32'hFFFF_FFFC, 32'h0,         32'h0,          1));

    #1;
    chk("rst_valid", {31'h0, dif.resp_valid_ro}, 32'h0);
    chk("rst_data", dif.resp_data_ro, 32'h0);
    chk("rst_err", {31'h0, dif.resp_err_ro}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready", {31'h0, dif.req_ready_o}, 32'h1);

    foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Response back-pressure: everything holds while resp_ready_i is low.
    dif.resp_ready_i = 1'b0;
    v = mk(0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hDE5A_BEEF, 0);
    drive(v);
    exp_q.push_back({v.exp, v.err});
    @(posedge clk); #1;
    dif.req_valid_i = 1'b0;
    seen = 0;
    while (!dif.resp_valid_ro && seen < 10) begin
      @(posedge clk); #1;
      seen++;
    end
    chk("stall_lat", seen, 32'd1);
    held = dif.resp_data_ro;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("stall_hold%0d", c),
          {29'h0, dif.resp_valid_ro, dif.req_ready_o, (dif.resp_data_ro === held)},
          32'b101);
    end
    dif.resp_ready_i = 1'b1;
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall_data", dif.resp_data_ro, e.data);
      chk("stall_err", {31'h0, dif.resp_err_ro}, {31'h0, e.err});
    end
    @(posedge clk); #1;
    chk("stall_release", {30'h0, dif.req_ready_o, dif.resp_valid_ro}, 32'b10);

    // Reset one cycle after a load is accepted drops the response entirely.
    v = mk(0, 2'b10, 0, 32'h0000_0020, 32'h0, 32'h0, 0);
    drive(v);
    @(posedge clk); #1;
    dif.req_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, dif.resp_valid_ro}, 32'h0);
    chk("mid_rst_data", dif.resp_data_ro, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (dif.resp_valid_ro) seen++;
    end
    chk("post_rst_no_resp", seen, 32'd0);
    chk("post_rst_ready", {31'h0, dif.req_ready_o}, 32'h1);
    run_vec(mk(0, 2'b10, 0, 32'h0000_0010, 32'h0, 32'hDE5A_BEEF, 0), "post_rst_a");
    run_vec(mk(0, 2'b10, 0, 32'h0000_0020, 32'h0, 32'h8000_007F, 0), "post_rst_b");

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words in the internal data array, power of two.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of word 0; must be DEPTH_WORDS*4 aligned.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 req_valid_i  input  1  request present.
REQ-006 req_ready_o  output  1  block can accept a request this cycle.
REQ-007 req_addr_i  input  32  byte address.
REQ-008 req_data_i  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 req_write_i  input  1  1 = store, 0 = load.
REQ-010 req_width_i  input  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-011 req_unsigned_i  input  1  load zero-extends when 1, sign-extends when 0.
REQ-012 resp_valid_ro  output  1  response present (registered).
REQ-013 resp_ready_i  input  1  downstream accepts response.
REQ-014 resp_data_ro  output  32  load result, right-aligned and extended; 0 for stores and errors.
REQ-015 resp_err_ro  output  1  request was misaligned, illegal width or out of range.

Function
REQ-016 Request handshake SHALL complete on a rising edge where req_valid_i and req_ready_o are both 1; request inputs are sampled only then.
REQ-017 State machine SHALL have states IDLE, READ, RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-018 IDLE -> READ on accepted legal load; IDLE -> RESP on accepted store or any accepted erroneous request; IDLE holds otherwise.
REQ-019 READ -> RESP unconditionally after one cycle; resp_data_ro loaded at that edge from the array word read at acceptance.
REQ-020 RESP -> IDLE on edge where resp_ready_i is 1; while resp_ready_i is 0, resp_valid_ro, resp_data_ro, resp_err_ro SHALL hold stable.
REQ-021 Latency: load accepted at edge N gives resp_valid_ro=1 after edge N+2; store/error accepted at edge N gives resp_valid_ro=1 after edge N+1.
REQ-022 Word index = (req_addr_i - BASE_ADDR) >> 2; request out of range when req_addr_i < BASE_ADDR or index >= DEPTH_WORDS.
REQ-023 Error when: width 11; width 01 with addr[0]=1; width 10 with addr[1:0]!=00; or out of range.
REQ-024 Erroneous store SHALL NOT modify the array; erroneous load SHALL NOT read-modify anything; both respond with resp_err_ro=1, resp_data_ro=0.
REQ-025 Legal store SHALL write at the acceptance edge using byte enables: byte -> lane addr[1:0]; half -> lanes {addr[1],0} and {addr[1],1}; word -> all four; data replicated so the low byte/half lands on the enabled lanes; non-enabled lanes unchanged.
REQ-026 Legal load SHALL select byte lane addr[1:0] or half at addr[1]*16, shift to bit 0, then zero- or sign-extend per req_unsigned_i; word loads ignore req_unsigned_i.
REQ-027 Store response SHALL have resp_err_ro=0, resp_data_ro=0.
REQ-028 A load to an address written by the immediately preceding store SHALL return the new data (store completes before next acceptance is possible).
REQ-029 Address arithmetic is 32-bit modulo; BASE_ADDR offset subtraction wrap-around counts as out of range.

Reset
REQ-030 On rst: state IDLE, resp_valid_ro=0, resp_data_ro=0, resp_err_ro=0; req_ready_o=1 once rst deasserts.
REQ-031 Array contents SHALL NOT be reset; a store committed before rst remains; an in-flight load or unconsumed response is discarded with no response issued.

Verification
REQ-032 Store word 32'hDEADBEEF to 0x10 (resp_ready_i=1), then load word 0x10 -> store ack err=0 after 1 cycle; load resp_data_ro=32'hDEADBEEF, err=0, valid exactly 2 cycles after acceptance.
REQ-033 After REQ-032, store byte 8'h5A to 0x12, load word 0x10 -> 32'hDE5ABEEF; load byte 0x13 signed -> 32'hFFFFFFDE; load byte 0x13 unsigned -> 32'h000000DE; load half 0x12 signed -> 32'hFFFFDE5A.
REQ-034 Store half to 0x11, load word 0x0E, width 11 request, load to BASE_ADDR+DEPTH_WORDS*4 -> each err=1, data=0; subsequent load word 0x10 unchanged.
REQ-035 Load accepted with resp_ready_i held 0 for 5 cycles -> resp_valid_ro and data stable throughout, req_ready_o=0 throughout, IDLE one edge after resp_ready_i=1.
REQ-036 Assert rst one cycle after load acceptance -> resp_valid_ro=0 immediately, no response after deassert, req_ready_o=1; earlier stored data still readable.
